// File: rtl/iter_muldiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package iter_muldiv_unit_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = '1;

  // Divide and remainder share the shift-subtract datapath.
  function automatic logic op_is_div(op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/iter_muldiv_unit_if.sv
// Operation request / result bus between the execute stage and the muldiv unit.
interface iter_muldiv_unit_if;

  logic                                  start;
  logic [1:0]                            op;
  logic [iter_muldiv_unit_pkg::WIDTH-1:0] data1;
  logic [iter_muldiv_unit_pkg::WIDTH-1:0] data2;
  logic                                  kill;
  logic [iter_muldiv_unit_pkg::WIDTH-1:0] result;
  logic                                  write;
  logic                                  busy;

  modport master (
    output start, op, data1, data2, kill,
    input  result, write, busy
  );

  modport slave (
    input  start, op, data1, data2, kill,
    output result, write, busy
  );

endinterface

// File: rtl/iter_muldiv_unit_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Accumulator layout is {hi, lo}; lo starts as DATA1 (multiplier / dividend).
module iter_muldiv_unit_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  input  logic           mode,
  output logic [2*W-1:0] acc_next,
  output logic           q_bit
);

  logic [W:0] sum;
  logic [W:0] partial;
  logic [W:0] diff;

  // mode=0: add operand into hi when lo[0] is set, then shift right.
  // mode=1: shift left one bit, subtract divisor when it fits; the quotient bit
  //         is returned separately and lands in acc_next[0] at the top.
  always_comb begin
    sum      = '0;
    partial  = '0;
    diff     = '0;
    acc_next = '0;
    q_bit    = 1'b0;
    if (!mode) begin
      sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {sum, acc[W-1:1]};
    end else begin
      partial = acc[2*W-1:W-1];
      diff    = partial - {1'b0, operand};
      if (partial >= {1'b0, operand}) begin
        q_bit    = 1'b1;
        acc_next = {diff[W-1:0], acc[W-2:0], 1'b0};
      end else begin
        acc_next = {partial[W-1:0], acc[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide unit.
// state | meaning
// IDLE  | waiting for start; last result held
// CALC  | one radix-2 step per cycle, WIDTH steps
// DONE  | load selected word into result, pulse write
module iter_muldiv_unit
  import iter_muldiv_unit_pkg::*;
(
  input logic               clk,
  input logic               reset,
  iter_muldiv_unit_if.slave bus
);

  state_e             state;
  op_e                op_q;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [WIDTH-1:0]   sel_word;

  iter_muldiv_unit_step #(.W(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opb),
    .mode     (op_is_div(op_q)),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Pick hi/lo word; a zero divisor bypasses the datapath (lo still holds DATA1).
  always_comb begin
    sel_word = op_q[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    if (op_is_div(op_q) && (opb == '0)) begin
      sel_word = op_q[0] ? acc[WIDTH-1:0] : DIV_ZERO_QUOT;
    end
  end

  // Control FSM with registered result/write/busy; busy spans the write cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op_q       <= OP_MUL;
      opb        <= '0;
      acc        <= '0;
      cnt        <= '0;
      bus.result <= '0;
      bus.write  <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      bus.write <= 1'b0;
      case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          if (bus.start && !bus.kill) begin
            op_q     <= op_e'(bus.op);
            opb      <= bus.data2;
            acc      <= {{WIDTH{1'b0}}, bus.data1};
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= (bus.op[1] && (bus.data2 == '0)) ? DONE : CALC;
          end
        end
        CALC: begin
          if (bus.kill) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (bus.kill) begin
            bus.busy <= 1'b0;
          end else begin
            bus.result <= sel_word;
            bus.write  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit: directed corner cases plus random ops.
module tb_iter_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  iter_muldiv_unit_if bus ();

  iter_muldiv_unit dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: result %h with no outstanding op", bus.result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("result", bus.result, e);
        last_result = e;
      end
    end
  end

  // Launch one op; check write latency, busy coverage and busy drop.
  // poke=1 asserts a second start during CALC, which must be ignored.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    int k;
    int exp_lat;
    bit found;
    bit busy_bad;
    exp_lat = (op[1] && b == 0) ? 1 : 33;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.data1 = a;
    bus.data2 = b;
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.data1 = $urandom;
    bus.data2 = $urandom;
    bus.op    = 2'($urandom_range(0, 3));
    busy_bad  = (bus.busy !== 1'b1);
    k = 0;
    found = 0;
    while (!found && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_bad = 1;
      if (bus.write === 1'b1) found = 1;
      if (poke && k == 5) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.data1 = $urandom;
        bus.data2 = $urandom;
      end
    end
    bus.start = 1'b0;
    check("latency", 32'(k), 32'(exp_lat));
    check("busy_during_op", 32'(busy_bad), 32'd0);
    @(posedge clk);
    #1;
    check("busy_after_write", 32'(bus.busy), 32'd0);
    check("write_single", 32'(bus.write), 32'd0);
  endtask

  // Kill after CALC cycle 10: no write, busy drops, result unchanged.
  task automatic kill_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit saw_write;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.data1 = a;
    bus.data2 = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    check("kill_busy", 32'(bus.busy), 32'd0);
    check("kill_result", bus.result, last_result);
    saw_write = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.write === 1'b1) saw_write = 1;
    end
    check("kill_no_write", 32'(saw_write), 32'd0);
    check("kill_result_hold", bus.result, last_result);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.kill  = 1'b0;
    #12;
    check("reset_result", bus.result, 32'd0);
    check("reset_write", 32'(bus.write), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(2'b00, 32'd7, 32'd6, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'd100, 32'd7, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b11, 32'd5, 32'd9, 0);
    run_op(2'b00, 32'd0, 32'd123, 0);
    run_op(2'b10, 32'd5, 32'd0, 0);
    run_op(2'b11, 32'd5, 32'd0, 0);

    kill_op(2'b10, 32'd1000, 32'd3);
    run_op(2'b01, 32'h8000_0001, 32'h0000_0003, 1);

    // Kill in IDLE wins over a simultaneous start.
    @(negedge clk);
    bus.start = 1'b1;
    bus.kill  = 1'b1;
    bus.op    = 2'b00;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    check("idle_kill_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      int mode;
      mode = $urandom_range(0, 3);
      a = $urandom;
      b = $urandom;
      if (mode == 1) begin
        a = $urandom_range(0, 20);
        b = $urandom_range(0, 20);
      end else if (mode == 2) begin
        b = '0;
      end else if (mode == 3) begin
        b = $urandom_range(1, 255);
      end
      run_op(2'($urandom_range(0, 3)), a, b, 0);
    end

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.data1 = 32'd3;
    bus.data2 = 32'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_write", 32'(bus.write), 32'd0);
    check("async_rst_result", bus.result, 32'd0);
    last_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b10, 32'd9, 32'd3, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
